// File: rtl/sort_seq_ctrl.sv
// Batch sorter: loads DEPTH (char, weight) entries, sorts them by odd-even transposition,
// then streams the characters out highest-rank first. Optional macro: SORT_SEQ_EARLY_EXIT_EN.
module sort_seq_ctrl #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_char,
  input  logic [4:0] in_weight,
  output logic       busy,
  output logic       out_valid,
  output logic [3:0] out_char
);

  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned WW  = 5;
  localparam int unsigned CHW = 4;

  typedef enum logic [1:0] {IDLE, LOAD, SORT, OUT} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            out_valid_q, out_valid_d;
  logic [CHW-1:0]  out_char_q, out_char_d;

  logic [WW-1:0]   w_q  [DEPTH];
  logic [WW-1:0]   w_d  [DEPTH];
  logic [WW-1:0]   sw_w [DEPTH];
  logic [CHW-1:0]  c_q  [DEPTH];
  logic [CHW-1:0]  c_d  [DEPTH];
  logic [CHW-1:0]  sw_c [DEPTH];

`ifdef SORT_SEQ_EARLY_EXIT_EN
  logic any_swap_c;
  logic prev_swap_q, prev_swap_d;
`endif

  // One transposition phase; cnt_q doubles as the phase counter while sorting.
  always_comb begin
    sw_w = w_q;
    sw_c = c_q;
`ifdef SORT_SEQ_EARLY_EXIT_EN
    any_swap_c = 1'b0;
`endif
    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      if ((i[0] == cnt_q[0]) && ({w_q[i+1], c_q[i+1]} > {w_q[i], c_q[i]})) begin
        sw_w[i]   = w_q[i+1];
        sw_w[i+1] = w_q[i];
        sw_c[i]   = c_q[i+1];
        sw_c[i+1] = c_q[i];
`ifdef SORT_SEQ_EARLY_EXIT_EN
        any_swap_c = 1'b1;
`endif
      end
    end
  end

  // Next-state, counter, storage and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    w_d         = w_q;
    c_d         = c_q;
    busy_d      = 1'b0;
    out_valid_d = 1'b0;
    out_char_d  = '0;
`ifdef SORT_SEQ_EARLY_EXIT_EN
    prev_swap_d = prev_swap_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          w_d[0]  = in_weight;
          c_d[0]  = in_char;
          cnt_d   = CW'(1);
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          for (int i = 0; i < int'(DEPTH); i++) begin
            if (CW'(i) == cnt_q) begin
              w_d[i] = in_weight;
              c_d[i] = in_char;
            end
          end
          if (cnt_q == CW'(DEPTH - 1)) begin
            cnt_d   = '0;
            state_d = SORT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      SORT: begin
        w_d   = sw_w;
        c_d   = sw_c;
        cnt_d = cnt_q + CW'(1);
`ifdef SORT_SEQ_EARLY_EXIT_EN
        prev_swap_d = any_swap_c;
        if ((cnt_q == CW'(DEPTH - 1)) ||
            ((cnt_q != '0) && !any_swap_c && !prev_swap_q)) begin
`else
        if (cnt_q == CW'(DEPTH - 1)) begin
`endif
          // Slot 0 is presented in the same edge that enters OUT.
          cnt_d       = CW'(1);
          state_d     = OUT;
          out_valid_d = 1'b1;
          out_char_d  = sw_c[0];
        end
      end
      OUT: begin
        if (cnt_q == CW'(DEPTH)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          out_valid_d = 1'b1;
          cnt_d       = cnt_q + CW'(1);
          for (int i = 0; i < int'(DEPTH); i++) begin
            if (CW'(i) == cnt_q) out_char_d = c_q[i];
          end
        end
      end
    endcase
    busy_d = (state_d == SORT) || (state_d == OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_char_q  <= '0;
`ifdef SORT_SEQ_EARLY_EXIT_EN
      prev_swap_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_char_q  <= out_char_d;
`ifdef SORT_SEQ_EARLY_EXIT_EN
      prev_swap_q <= prev_swap_d;
`endif
    end
  end

  // Entry storage is not reset; it is always rewritten before being read.
  always_ff @(posedge clk) begin
    w_q <= w_d;
    c_q <= c_d;
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_char  = out_char_q;

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Bench for sort_seq_ctrl: DEPTH=8 and DEPTH=2 instances checked against a queue-sort model.
module tb_sort_seq_ctrl;

`ifdef SORT_SEQ_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v8, busy8, ov8;
  logic [3:0] ch8, oc8;
  logic [4:0] wt8;
  logic       v2, busy2, ov2;
  logic [3:0] ch2, oc2;
  logic [4:0] wt2;

  int errors = 0;
  int checks = 0;

  logic [4:0] wa [8];
  logic [3:0] ca [8];

  always #5 clk = ~clk;

  sort_seq_ctrl #(.DEPTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_char(ch8), .in_weight(wt8),
    .busy(busy8), .out_valid(ov8), .out_char(oc8)
  );

  sort_seq_ctrl #(.DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_char(ch2), .in_weight(wt2),
    .busy(busy2), .out_valid(ov2), .out_char(oc2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic rand_batch();
    for (int i = 0; i < 8; i++) begin
      wa[i] = ($urandom_range(0, 1) == 1) ? 5'($urandom) : 5'($urandom_range(0, 3));
      ca[i] = 4'($urandom);
    end
  endtask

  task automatic load8(input int gap);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v8 = 1'b1; ch8 = ca[i]; wt8 = wa[i];
      if (i < 7) begin
        repeat (gap) begin
          @(negedge clk);
          v8 = 1'b0; ch8 = 4'($urandom); wt8 = 5'($urandom);
        end
      end
    end
  endtask

  // exp_lat < 0: only the no-early-exit upper bound applies.
  task automatic expect8(input int exp_lat, input bit pulse);
    logic [8:0] keys [$];
    int lat;
    bit seen;
    for (int i = 0; i < 8; i++) keys.push_back({wa[i], ca[i]});
    keys.rsort();
    lat = 0;
    seen = 1'b0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(negedge clk);
      if (ov8) begin
        seen = 1'b1;
        lat = n;
      end else begin
        chk("busy_sort", 32'(busy8), 32'd1);
      end
      v8 = pulse ? 1'($urandom) : 1'b0; ch8 = 4'($urandom); wt8 = 5'($urandom);
    end
    chk("out_seen", 32'(seen), 32'd1);
    if (!seen) begin
      v8 = 1'b0;
      return;
    end
    if (exp_lat >= 0) chk("latency", 32'(lat), 32'(exp_lat));
    else chk("latency_max", 32'(lat <= 9), 32'd1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      chk("out_valid", 32'(ov8), 32'd1);
      chk("busy_out", 32'(busy8), 32'd1);
      chk("out_char", 32'(oc8), 32'(keys[k][3:0]));
      v8 = pulse ? ((k == 7) ? 1'b1 : 1'($urandom)) : 1'b0;
      ch8 = 4'($urandom); wt8 = 5'($urandom);
    end
    @(negedge clk);
    chk("idle_valid", 32'(ov8), 32'd0);
    chk("idle_char", 32'(oc8), 32'd0);
    chk("idle_busy", 32'(busy8), 32'd0);
    v8 = 1'b0;
  endtask

  task automatic run2(input logic [4:0] w0, input logic [3:0] c0,
                      input logic [4:0] w1, input logic [3:0] c1);
    logic [8:0] keys [$];
    int nbusy;
    int nout;
    keys.push_back({w0, c0});
    keys.push_back({w1, c1});
    keys.rsort();
    @(negedge clk); v2 = 1'b1; wt2 = w0; ch2 = c0;
    @(negedge clk); v2 = 1'b1; wt2 = w1; ch2 = c1;
    nbusy = 0;
    nout = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy2) nbusy++;
      if (ov2) begin
        if (nout < 2) chk("d2_out_char", 32'(oc2), 32'(keys[nout][3:0]));
        nout++;
      end else begin
        chk("d2_idle_char", 32'(oc2), 32'd0);
      end
      v2 = 1'b0;
    end
    chk("d2_busy_cycles", 32'(nbusy), 32'd4);
    chk("d2_out_count", 32'(nout), 32'd2);
  endtask

  initial begin
    int cnt;
    bit seen;
    rst_n = 1'b0;
    v8 = 1'b0; ch8 = '0; wt8 = '0;
    v2 = 1'b0; ch2 = '0; wt2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_valid8", 32'(ov8), 32'd0);
    chk("rst_char8", 32'(oc8), 32'd0);
    chk("rst_busy2", 32'(busy2), 32'd0);
    chk("rst_valid2", 32'(ov2), 32'd0);
    chk("rst_char2", 32'(oc2), 32'd0);
    rst_n = 1'b1;

    // Ascending weights: fully reversed order, full SORT length.
    for (int i = 0; i < 8; i++) begin
      wa[i] = 5'(i + 1);
      ca[i] = 4'(i);
    end
    load8(0);
    expect8(9, 1'b0);

    // Equal weights: ordering by char only.
    for (int i = 0; i < 8; i++) wa[i] = 5'd5;
    ca[0] = 4'd3; ca[1] = 4'd9; ca[2] = 4'd1; ca[3] = 4'd15;
    ca[4] = 4'd0; ca[5] = 4'd7; ca[6] = 4'd2; ca[7] = 4'd8;
    load8(0);
    expect8(EE ? -1 : 9, 1'b0);

    // Same batch with gaps during load and stray in_valid during SORT/OUT.
    load8(1);
    expect8(EE ? -1 : 9, 1'b1);

    // Already-sorted batch.
    for (int i = 0; i < 8; i++) begin
      wa[i] = 5'(31 - i);
      ca[i] = 4'($urandom);
    end
    load8(0);
    expect8(EE ? 3 : 9, 1'b0);

    repeat (8) begin
      rand_batch();
      load8($urandom_range(0, 2));
      expect8(EE ? -1 : 9, 1'($urandom));
    end

    // Reset part-way through a load discards the partial batch.
    rand_batch();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      v8 = 1'b1; ch8 = ca[i]; wt8 = wa[i];
    end
    @(negedge clk);
    v8 = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_load_busy", 32'(busy8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rand_batch();
    load8(0);
    expect8(EE ? -1 : 9, 1'b0);

    // Reset in the third OUT cycle.
    rand_batch();
    load8(0);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      v8 = 1'b0;
      if (ov8) seen = 1'b1;
    end
    chk("rst_out_seen", 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(ov8), 32'd0);
    chk("rst_out_char", 32'(oc8), 32'd0);
    chk("rst_out_busy", 32'(busy8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (ov8 || busy8) cnt++;
    end
    chk("quiet_after_rst", 32'(cnt), 32'd0);
    rand_batch();
    load8(0);
    expect8(EE ? -1 : 9, 1'b0);

    // DEPTH=2 instance.
    run2(5'd4, 4'd1, 5'd4, 4'd2);
    repeat (3) run2(5'($urandom), 4'($urandom), 5'($urandom_range(0, 2)), 4'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sort_seq_ctrl.md
SORT_SEQ_CTRL -- requirements
Module: sort_seq_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the number of entries per batch; legal values are even numbers 2..8.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: qualifies in_char and in_weight for one entry.
REQ-005 SHALL have port in_char, input, 4 bits: entry character code.
REQ-006 SHALL have port in_weight, input, 5 bits: entry weight, unsigned.
REQ-007 SHALL have port busy, output, 1 bit: high in SORT and OUT states.
REQ-008 SHALL have port out_valid, output, 1 bit: qualifies out_char.
REQ-009 SHALL have port out_char, output, 4 bits: sorted character, driven 0 whenever out_valid is low.

Function
REQ-010 SHALL implement four states: IDLE, LOAD, SORT, OUT; all outputs registered.
REQ-011 IDLE: in_valid=1 SHALL write the entry to slot 0 and move to LOAD with load count 1.
REQ-012 LOAD: each cycle with in_valid=1 SHALL write the entry to slot[count] and increment count; cycles with in_valid=0 SHALL hold state and count (gaps allowed).
REQ-013 When the DEPTH-th entry is written, the next state SHALL be SORT with phase counter 0.
REQ-014 SORT SHALL run one odd-even transposition phase per cycle: even phase compares pairs (0,1),(2,3),...; odd phase compares (1,2),(3,4),...,(DEPTH-3,DEPTH-2); phase 0 is even.
REQ-015 Order rule: entry A precedes B if A.weight > B.weight, or weights equal and A.char > B.char; a pair out of order SHALL swap weight and character together.
REQ-016 Without early exit, SORT SHALL last exactly DEPTH cycles, then move to OUT.
REQ-017 OUT SHALL assert out_valid for exactly DEPTH consecutive cycles, emitting slot 0 (highest rank) first through slot DEPTH-1, then return to IDLE.
REQ-018 Latency: with the last entry accepted in cycle t, first out_valid SHALL occur in cycle t+DEPTH+1 (no early exit).
REQ-019 in_valid during SORT or OUT SHALL be ignored; no entry is stored and no state changes.
REQ-020 in_valid in the last OUT cycle SHALL be ignored; a new batch starts only from IDLE.
REQ-021 Duplicate entries (same weight and char) SHALL be emitted as many times as loaded.
REQ-022 DEPTH=2: odd phases SHALL compare no pairs.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, load/phase/output counters 0, busy=0, out_valid=0, out_char=0, regardless of state.
REQ-024 Reset mid-LOAD, mid-SORT or mid-OUT SHALL discard the batch; no further out_valid until a full new batch is loaded.
REQ-025 Storage slots need not be reset; they SHALL never be observable before being rewritten.

Configuration
REQ-026 Macro SORT_SEQ_EARLY_EXIT_EN SHALL enable early termination of SORT.
REQ-027 With SORT_SEQ_EARLY_EXIT_EN defined: after phase p (p>=1), if phases p and p-1 both performed zero swaps, next state SHALL be OUT; otherwise behaviour per REQ-016.
REQ-028 Without SORT_SEQ_EARLY_EXIT_EN: SORT always lasts DEPTH cycles; no swap-detect logic present.
REQ-029 Output sequence SHALL be identical with and without the macro; only latency differs.

Verification
REQ-030 DEPTH=8, weights 1..8 in ascending order, chars 0..7 contiguous -> out_char 7,6,5,4,3,2,1,0; first out_valid 9 cycles after last input.
REQ-031 All weights 5, chars 3,9,1,15,0,7,2,8 -> out_char 15,9,8,7,3,2,1,0.
REQ-032 Already-sorted batch (weights 31 down to 24) with macro defined -> SORT lasts 2 cycles, first out_valid 3 cycles after last input; without macro 9 cycles.
REQ-033 Load with in_valid gaps (1 idle cycle between entries) and in_valid pulses during SORT/OUT -> same output as gap-free load; extra pulses produce no effect.
REQ-034 rst_n pulsed low in the 3rd OUT cycle -> out_valid and out_char 0 immediately; next full batch sorts correctly.
REQ-035 DEPTH=2, entries (w=4,c=1),(w=4,c=2) -> out_char 2,1; busy high for exactly 4 cycles.
